// File: rtl/comp4_search_ctrl.sv
// Key-search controller that time-shares one external 4-bit equality comparator
// across a DEPTH-entry table and reports the lowest matching index.
//
// state | meaning
// IDLE  | table writable, waiting for start
// SCAN  | one table entry compared per cycle via cmp_a/cmp_b/cmp_eq
// DONE  | one-cycle completion pulse, result registers already updated
module comp4_search_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             start,
  input  logic [3:0]       key,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] match_idx,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    RSVD = 2'd3
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_V  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [3:0]       tbl [DEPTH];
  logic [3:0]       key_r;
  logic [IDX_W-1:0] idx_q;
  logic             wr_ok;
  logic             last;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_V);
  assign last  = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (cmp_eq || last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Comparator operands come only from registered state, never from start/key.
  assign busy  = (state_q == SCAN) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign cmp_a = (state_q == SCAN) ? tbl[idx_q] : 4'd0;
  assign cmp_b = (state_q == SCAN) ? key_r      : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      key_r     <= '0;
      hit       <= 1'b0;
      match_idx <= '0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en && wr_ok) tbl[wr_addr] <= wr_data;
          if (start) begin
            key_r <= key;
            idx_q <= '0;
          end
        end
        SCAN: begin
          if (cmp_eq) begin
            hit       <= 1'b1;
            match_idx <= idx_q;
          end else if (last) begin
            hit       <= 1'b0;
            match_idx <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
